// File: rtl/cache_event_counter_bank.sv
// Performance-event counter bank: N level/edge event channels plus a cycle counter, wrap or saturate, sticky overflow, snapshot readout under CACHE_PERF_SNAPSHOT_EN.
// Latency: counters update the edge after an event is sampled; rdata_o and overflow_o are registered, one cycle behind sel_i/flags.
// Backpressure: none; every cycle performs one read and event strobes are never stalled.
module cache_event_counter_bank #(
  parameter int                  N_EVENTS      = 8,
  parameter int                  COUNTER_WIDTH = 64,
  parameter logic [N_EVENTS-1:0] EDGE_MASK     = '0,
  parameter bit                  SATURATE      = 1'b0,
  parameter logic [31:0]         CACHE_ID      = 32'h0
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic [N_EVENTS-1:0] chan_en_i,
  input  logic [N_EVENTS-1:0] event_i,
  input  logic                clear_i,
  input  logic                snapshot_i,
  input  logic [7:0]          sel_i,
  output logic [31:0]         rdata_o,
  output logic                overflow_o
);

  localparam int         NCNT      = N_EVENTS + 1;
  localparam int         NWORDS    = (COUNTER_WIDTH + 31) / 32;
  localparam logic [5:0] IDX_FLAGS = 6'd62;
  localparam logic [5:0] IDX_ID    = 6'd63;

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;

  cnt_t                cnt_q [NCNT];
  cnt_t                cnt_d [NCNT];
  logic [N_EVENTS:0]   ovf_q;
  logic [N_EVENTS-1:0] prev_q;
  logic [N_EVENTS:0]   hit;
  logic [N_EVENTS:0]   wrap;

  // Index N_EVENTS is the cycle counter; it ignores chan_en_i and edge mode.
  always_comb begin
    hit[N_EVENTS] = enable_i;
    for (int c = 0; c < N_EVENTS; c++) begin
      hit[c] = enable_i & chan_en_i[c] & event_i[c] & (~EDGE_MASK[c] | ~prev_q[c]);
    end
  end

  always_comb begin
    for (int c = 0; c < NCNT; c++) begin
      cnt_d[c] = cnt_q[c];
      wrap[c]  = hit[c] & (&cnt_q[c]);
      if (hit[c] && !(wrap[c] && SATURATE)) begin
        cnt_d[c] = cnt_q[c] + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int c = 0; c < NCNT; c++) cnt_q[c] <= '0;
      ovf_q  <= '0;
      prev_q <= '0;
    end else begin
      prev_q <= event_i;
      if (clear_i) begin
        for (int c = 0; c < NCNT; c++) cnt_q[c] <= '0;
        ovf_q <= '0;
      end else begin
        for (int c = 0; c < NCNT; c++) cnt_q[c] <= cnt_d[c];
        ovf_q <= ovf_q | wrap;
      end
    end
  end

  cnt_t              src_cnt [NCNT];
  logic [N_EVENTS:0] src_ovf;

`ifdef CACHE_PERF_SNAPSHOT_EN
  cnt_t              snap_q [NCNT];
  logic [N_EVENTS:0] snap_ovf_q;

  // Snapshot bank survives clear_i so a read-and-clear keeps the old values.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int c = 0; c < NCNT; c++) snap_q[c] <= '0;
      snap_ovf_q <= '0;
    end else if (snapshot_i) begin
      for (int c = 0; c < NCNT; c++) snap_q[c] <= cnt_q[c];
      snap_ovf_q <= ovf_q;
    end
  end

  always_comb begin
    for (int c = 0; c < NCNT; c++) src_cnt[c] = snap_q[c];
    src_ovf = snap_ovf_q;
  end
`else
  logic snapshot_unused;
  assign snapshot_unused = snapshot_i;

  always_comb begin
    for (int c = 0; c < NCNT; c++) src_cnt[c] = cnt_q[c];
    src_ovf = ovf_q;
  end
`endif

  logic [5:0]   sel_idx;
  logic [1:0]   sel_word;
  logic [127:0] sel_wide;
  logic [31:0]  rdata_d;

  assign sel_idx  = sel_i[7:2];
  assign sel_word = sel_i[1:0];

  // Sources are zero-extended to four words so any word slice is well defined.
  always_comb begin
    sel_wide = '0;
    for (int c = 0; c < NCNT; c++) begin
      if (sel_idx == 6'(c)) sel_wide = 128'(src_cnt[c]);
    end
    if (sel_idx == IDX_FLAGS) sel_wide = 128'(src_ovf);
    rdata_d = sel_wide[{sel_word, 5'b00000} +: 32];
    if (int'(sel_word) >= NWORDS) rdata_d = '0;
    if (sel_idx == IDX_ID) rdata_d = (sel_word == 2'd0) ? CACHE_ID : 32'h0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rdata_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      rdata_o    <= rdata_d;
      overflow_o <= |ovf_q;
    end
  end

endmodule

// File: tb/tb_cache_event_counter_bank.sv
// Scoreboarded bench for cache_event_counter_bank: three instances (64-bit wrap, 4-bit wrap, 4-bit saturate) share one stimulus stream.
module tb_cache_event_counter_bank;

  localparam logic [31:0] ID = 32'hCAC4E001;
`ifdef CACHE_PERF_SNAPSHOT_EN
  localparam bit SNAP_ON = 1'b1;
`else
  localparam bit SNAP_ON = 1'b0;
`endif

  logic        clock_i = 1'b0;
  logic        reset_i, enable_i, clear_i, snapshot_i;
  logic [7:0]  chan_en_i, event_i, sel_i;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        ov_a, ov_b, ov_c;

  always #5 clock_i = ~clock_i;

  cache_event_counter_bank #(.N_EVENTS(8), .COUNTER_WIDTH(64), .EDGE_MASK(8'h02), .SATURATE(1'b0), .CACHE_ID(ID)) dut_a (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .chan_en_i(chan_en_i), .event_i(event_i),
    .clear_i(clear_i), .snapshot_i(snapshot_i), .sel_i(sel_i), .rdata_o(rd_a), .overflow_o(ov_a));
  cache_event_counter_bank #(.N_EVENTS(8), .COUNTER_WIDTH(4), .EDGE_MASK(8'h02), .SATURATE(1'b0), .CACHE_ID(ID)) dut_b (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .chan_en_i(chan_en_i), .event_i(event_i),
    .clear_i(clear_i), .snapshot_i(snapshot_i), .sel_i(sel_i), .rdata_o(rd_b), .overflow_o(ov_b));
  cache_event_counter_bank #(.N_EVENTS(8), .COUNTER_WIDTH(4), .EDGE_MASK(8'h02), .SATURATE(1'b1), .CACHE_ID(ID)) dut_c (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .chan_en_i(chan_en_i), .event_i(event_i),
    .clear_i(clear_i), .snapshot_i(snapshot_i), .sel_i(sel_i), .rdata_o(rd_c), .overflow_o(ov_c));

  typedef struct {
    string       name;
    logic [31:0] ea, eb, ec;
    logic        oa, ob, oc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rd_issue = 1'b0;
  logic rd_vld   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // A read issued before edge k has its data on rdata_o after edge k.
  always @(posedge clock_i) rd_vld <= rd_issue;

  always @(negedge clock_i) begin
    if (rd_vld) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: read data with empty expectation queue");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "/rd_a"}, rd_a, e.ea);
        chk({e.name, "/rd_b"}, rd_b, e.eb);
        chk({e.name, "/rd_c"}, rd_c, e.ec);
        chk({e.name, "/ov_a"}, 32'(ov_a), 32'(e.oa));
        chk({e.name, "/ov_b"}, 32'(ov_b), 32'(e.ob));
        chk({e.name, "/ov_c"}, 32'(ov_c), 32'(e.oc));
      end
    end
  end

  task automatic tick();
    @(negedge clock_i);
  endtask

  task automatic rd(input string nm, input logic [5:0] idx, input logic [1:0] w,
                    input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                    input logic oa, input logic ob, input logic oc);
    exp_t e;
    e.name = nm; e.ea = ea; e.eb = eb; e.ec = ec; e.oa = oa; e.ob = ob; e.oc = oc;
    sel_i    = {idx, w};
    rd_issue = 1'b1;
    q.push_back(e);
    tick();
    rd_issue = 1'b0;
  endtask

  // With the snapshot bank present, reads see the bank, so refresh it while counting is frozen.
  task automatic sync_snap();
    if (SNAP_ON) begin
      snapshot_i = 1'b1;
      tick();
      snapshot_i = 1'b0;
    end
  endtask

  task automatic run(input int n, input logic [7:0] ev);
    enable_i = 1'b1;
    event_i  = ev;
    repeat (n) tick();
    enable_i = 1'b0;
    event_i  = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; enable_i = 1'b0; chan_en_i = 8'hFF; event_i = 8'h00;
    clear_i = 1'b0; snapshot_i = 1'b0; sel_i = 8'h00;
    tick(); tick();
    reset_i = 1'b0;

    rd("reset_ch0",   6'd0,  2'd0, 0, 0, 0, 0, 0, 0);
    rd("reset_cycle", 6'd8,  2'd0, 0, 0, 0, 0, 0, 0);
    rd("reset_flags", 6'd62, 2'd0, 0, 0, 0, 0, 0, 0);

    // Level count: 10 cycles on channel 0.
    run(10, 8'h01);
    sync_snap();
    rd("level_ch0_w0", 6'd0, 2'd0, 10, 10, 10, 0, 0, 0);
    rd("level_ch0_w1", 6'd0, 2'd1, 0, 0, 0, 0, 0, 0);
    rd("level_cycle",  6'd8, 2'd0, 10, 10, 10, 0, 0, 0);

    // Channel 1 edge mode, channel 2 level mode: high 5, low 1, high 3.
    enable_i = 1'b1;
    event_i = 8'h06; repeat (5) tick();
    event_i = 8'h00; tick();
    event_i = 8'h06; repeat (3) tick();
    enable_i = 1'b0; event_i = 8'h00;
    sync_snap();
    rd("edge_ch1",    6'd1,  2'd0, 2, 2, 2, 0, 1, 1);
    rd("level_ch2",   6'd2,  2'd0, 8, 8, 8, 0, 1, 1);
    rd("cycle_19",    6'd8,  2'd0, 19, 3, 15, 0, 1, 1);
    rd("cycle_flag",  6'd62, 2'd0, 0, 32'h100, 32'h100, 0, 1, 1);

    // 17 events into a 4-bit counter: wrap reads 1, saturate reads 15.
    run(17, 8'h08);
    sync_snap();
    rd("ovf_ch3",    6'd3,  2'd0, 17, 1, 15, 0, 1, 1);
    rd("ovf_flags",  6'd62, 2'd0, 0, 32'h108, 32'h108, 0, 1, 1);
    rd("ovf_cycle",  6'd8,  2'd0, 36, 4, 15, 0, 1, 1);

    rd("map_id_w0",  6'd63, 2'd0, ID, ID, ID, 0, 1, 1);
    rd("map_id_w1",  6'd63, 2'd1, 0, 0, 0, 0, 1, 1);
    rd("map_idx40",  6'd40, 2'd0, 0, 0, 0, 0, 1, 1);
    rd("map_word3",  6'd3,  2'd3, 0, 0, 0, 0, 1, 1);
    rd("map_word1",  6'd3,  2'd1, 0, 0, 0, 0, 1, 1);

    // Clear collides with an event and a cycle increment.
    clear_i = 1'b1; enable_i = 1'b1; event_i = 8'h01;
    tick();
    clear_i = 1'b0; enable_i = 1'b0; event_i = 8'h00;
    chk("clear_ov_b_lag", 32'(ov_b), 32'd1);
    tick();
    chk("clear_ov_b_fall", 32'(ov_b), 32'd0);
    chk("clear_ov_c_fall", 32'(ov_c), 32'd0);
    sync_snap();
    rd("clear_ch0",   6'd0,  2'd0, 0, 0, 0, 0, 0, 0);
    rd("clear_cycle", 6'd8,  2'd0, 0, 0, 0, 0, 0, 0);
    rd("clear_flags", 6'd62, 2'd0, 0, 0, 0, 0, 0, 0);

    // Read-and-clear snapshot with a colliding event, then 4 more events.
    run(7, 8'h01);
    snapshot_i = 1'b1; clear_i = 1'b1; enable_i = 1'b1; event_i = 8'h01;
    tick();
    snapshot_i = 1'b0; clear_i = 1'b0;
    run(4, 8'h01);
    rd("snap_first",  6'd0, 2'd0, SNAP_ON ? 7 : 4, SNAP_ON ? 7 : 4, SNAP_ON ? 7 : 4, 0, 0, 0);
    snapshot_i = 1'b1;
    tick();
    snapshot_i = 1'b0;
    rd("snap_second", 6'd0, 2'd0, 4, 4, 4, 0, 0, 0);
    rd("snap_cycle",  6'd8, 2'd0, 4, 4, 4, 0, 0, 0);

    // Reset in the middle of counting discards everything.
    run(20, 8'hFF);
    enable_i = 1'b1; event_i = 8'hFF; reset_i = 1'b1;
    tick();
    reset_i = 1'b0; enable_i = 1'b0; event_i = 8'h00;
    chk("mid_reset_rd_a", rd_a, 32'd0);
    chk("mid_reset_rd_b", rd_b, 32'd0);
    chk("mid_reset_ov_b", 32'(ov_b), 32'd0);
    sync_snap();
    rd("mid_reset_ch0",   6'd0,  2'd0, 0, 0, 0, 0, 0, 0);
    rd("mid_reset_ch7",   6'd7,  2'd0, 0, 0, 0, 0, 0, 0);
    rd("mid_reset_cycle", 6'd8,  2'd0, 0, 0, 0, 0, 0, 0);
    rd("mid_reset_flags", 6'd62, 2'd0, 0, 0, 0, 0, 0, 0);

    tick(); tick();
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_event_counter_bank.md
# cache_event_counter_bank

Parametrised performance-event counter bank for the cache subsystem: N independent event channels plus a free-running cycle counter, each COUNTER_WIDTH bits, with per-channel level/edge counting, wrap or saturate arithmetic, sticky overflow flags and atomic snapshot readout. It sits beside a cache controller, takes its single-cycle event strobes, and returns counter words to the host-side configuration/readout path through a registered select/data port.

## Interface
- N_EVENTS, 8, number of event channels, legal 1..32
- COUNTER_WIDTH, 64, counter width in bits, legal 1..128; read as ceil(COUNTER_WIDTH/32) words
- EDGE_MASK, 0, N_EVENTS-bit mask; bit c=1 counts rising edges of event_i[c], else counts high cycles
- SATURATE, 0, 0 = counters wrap, 1 = counters hold at all-ones
- CACHE_ID, 0, 32-bit constant returned at identification index
- clock_i  input  1  sole clock, all state on rising edge
- reset_i  input  1  synchronous, active-high reset
- enable_i  input  1  global count enable (events and cycle counter)
- chan_en_i  input  N_EVENTS  per-channel enable, ANDed with enable_i
- event_i  input  N_EVENTS  event strobes from the cache
- clear_i  input  1  zero all counters and overflow flags
- snapshot_i  input  1  copy all live counters/flags to snapshot bank
- sel_i  input  8  readout select: [7:2] channel index, [1:0] word index
- rdata_o  output  32  selected word, registered
- overflow_o  output  1  OR of all sticky overflow flags, registered

## Operation
- Channel c increments by 1 when enable_i & chan_en_i[c] & hit, hit = event_i[c] (level) or event_i[c] & !prev[c] (edge).
- prev[c] samples event_i[c] every cycle regardless of enables; reset value 0.
- Cycle counter (index N_EVENTS) increments every cycle enable_i=1; ignores chan_en_i.
- Increment from all-ones: SATURATE=0 -> wraps to 0; SATURATE=1 -> stays all-ones. Either way overflow flag of that channel sets and stays set until clear_i or reset_i. Cycle counter has flag bit N_EVENTS.
- Priority per edge: reset_i > clear_i > increment. clear_i with a same-cycle event leaves counter at 0.
- Readout index map: 0..N_EVENTS-1 event channels; N_EVENTS cycle counter; 62 overflow flags word 0 ([N_EVENTS:0], upper bits 0); 63 CACHE_ID (word 0 only); all other indices, and words at or beyond ceil(COUNTER_WIDTH/32), return 0. Word w = bits [32w+31:32w], zero-extended above COUNTER_WIDTH.

## Timing
- Reset: all counters, flags, prev, snapshot bank, rdata_o = 0, overflow_o = 0, one edge after reset_i sampled high; reset mid-count discards everything.
- Counter update visible in the register the edge after the event is sampled.
- rdata_o: 1-cycle latency; value after edge k+1 reflects sel_i and the source state as of edge k (pre-update values of that edge).
- overflow_o: registered OR of flags, one cycle behind flag set; falls the edge after clear_i.
- snapshot_i at edge k captures pre-edge counter/flag values, so an event sampled at edge k is excluded. snapshot_i with clear_i in the same cycle gives read-and-clear: snapshot holds old values, live counters become 0.
- No handshake; sel_i may change every cycle, each cycle produces one read.

## Configuration
- CACHE_PERF_SNAPSHOT_EN defined: snapshot bank instantiated; readout indices 0..N_EVENTS and 62 return snapshot values; live counters never read directly; snapshot bank cleared only by reset_i, not clear_i.
- Undefined: no snapshot storage; snapshot_i ignored; readout returns live counters and live flags with the same 1-cycle latency.

## Test plan
- Level count: N_EVENTS=8, enable_i=1, chan_en_i=0xFF, event_i[0] high 10 cycles -> channel 0 reads 10 word 0, 0 word 1; cycle counter equals enabled cycles.
- Edge count: EDGE_MASK bit 1 set, event_i[1] high 5 cycles, low, high 3 cycles -> channel 1 = 2; same in level mode = 8.
- Overflow: COUNTER_WIDTH=4, 17 events -> SATURATE=0 reads 1, SATURATE=1 reads 15; flag bit set at index 62, overflow_o=1 until clear_i.
- Clear/event collision: clear_i and event_i[0] same cycle -> channel 0 = 0 next cycle; flags 0, overflow_o falls next edge.
- Snapshot (macro on): count 7, snapshot_i+clear_i with event same cycle, 4 more events -> reads 7 (snapshot), repeat snapshot -> reads 4; macro off -> reads live 4 with snapshot_i ignored.
- Readout map: sel_i index 63 -> CACHE_ID; index 40 -> 0; word 3 with COUNTER_WIDTH=64 -> 0; reset_i mid-run -> rdata_o 0 and all counters 0.
